// File: rtl/aes_shift_rows_pipe_if.sv
// Valid/ready word stream carrying an AES state and its ShiftRows direction flag.
// The master drives valid/data/inverse; the slave answers with ready.
interface aes_shift_rows_pipe_if #(
   parameter int unsigned W = 128
);
   logic         valid;
   logic         ready;
   logic [W-1:0] data;
   logic         inverse;

   modport master (output valid, output data, output inverse, input ready);
   modport slave  (input valid, input data, input inverse, output ready);
endinterface

// File: rtl/aes_shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows/InvShiftRows for NB = 4/6/8 columns, with an
// elastic valid/ready register chain of PIPE_DEPTH stages.
module aes_shift_rows_pipe #(
   parameter int unsigned NB               = 4,
   parameter int unsigned PIPE_DEPTH       = 2,
   parameter bit          ROW_OFFSETS_AUTO = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   aes_shift_rows_pipe_if.slave  in_bus,
   aes_shift_rows_pipe_if.master out_bus,
   output logic [2:0]            occupancy
);

   localparam int unsigned W      = 32 * NB;
   localparam int unsigned NBYTES = 4 * NB;

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
   end
   if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
      $error("aes_shift_rows_pipe: PIPE_DEPTH must be 1..4");
   end

   function automatic int unsigned row_off(input int unsigned r);
      if (!ROW_OFFSETS_AUTO) return r;
      case (r)
         0:       return 0;
         1:       return 1;
         2:       return (NB == 8) ? 3 : 2;
         default: return (NB == 8) ? 4 : 3;
      endcase
   endfunction

   logic [W-1:0]            perm;
   logic [PIPE_DEPTH-1:0]   valid;
   logic [W-1:0]            data [PIPE_DEPTH];
   logic                    inv  [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0]   ready;
   logic [PIPE_DEPTH-1:0]   up_valid;
   logic [W-1:0]            up_data [PIPE_DEPTH];
   logic                    up_inv  [PIPE_DEPTH];
   logic                    full_from;
   logic                    accept;

   // Byte k sits at row k%4, column k/4; pick the source column per row offset.
   always_comb begin
      perm = '0;
      for (int unsigned k = 0; k < NBYTES; k++) begin
         int unsigned r, c, sc;
         r  = k % 4;
         c  = k / 4;
         sc = in_bus.inverse ? (c + NB - row_off(r)) % NB : (c + row_off(r)) % NB;
         perm[(NBYTES-1-k)*8 +: 8] = in_bus.data[(NBYTES-1-(sc*4+r))*8 +: 8];
      end
   end

   // ready_i = ~valid_i | ready_{i+1} unrolled: a stage blocks only when it and
   // every stage after it are full and the consumer stalls.
   always_comb begin
      full_from = 1'b1;
      ready     = '0;
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
         full_from = 1'b1;
         for (int unsigned j = i; j < PIPE_DEPTH; j++) full_from = full_from & valid[j];
         ready[i] = ~full_from | out_bus.ready;
      end
   end

   assign in_bus.ready = ready[0] & ~flush & ~rst;
   assign accept       = in_bus.valid & in_bus.ready;

   always_comb begin
      up_valid[0] = accept;
      up_data[0]  = perm;
      up_inv[0]   = in_bus.inverse;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
         up_valid[i] = valid[i-1];
         up_data[i]  = data[i-1];
         up_inv[i]   = inv[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
         for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            data[i] <= '0;
            inv[i]  <= 1'b0;
         end
      end else if (flush) begin
         valid <= '0;
      end else begin
         for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            if (ready[i]) begin
               valid[i] <= up_valid[i];
               if (up_valid[i]) begin
                  data[i] <= up_data[i];
                  inv[i]  <= up_inv[i];
               end
            end
         end
      end
   end

   assign out_bus.valid   = valid[PIPE_DEPTH-1];
   assign out_bus.data    = data[PIPE_DEPTH-1];
   assign out_bus.inverse = inv[PIPE_DEPTH-1];

   always_comb begin
      occupancy = '0;
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) occupancy = occupancy + {2'b00, valid[i]};
   end

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Self-checking bench for aes_shift_rows_pipe: NB=4 and NB=8 instances checked
// against a byte-array ShiftRows model through per-instance scoreboards.
module tb_aes_shift_rows_pipe;

   localparam int D = 2;

   typedef struct {
      logic [255:0] d;
      logic         inv;
      int           cyc;
   } item_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic [2:0] occ4, occ8;

   aes_shift_rows_pipe_if #(.W(128)) i4 ();
   aes_shift_rows_pipe_if #(.W(128)) o4 ();
   aes_shift_rows_pipe_if #(.W(256)) i8 ();
   aes_shift_rows_pipe_if #(.W(256)) o8 ();

   aes_shift_rows_pipe #(.NB(4), .PIPE_DEPTH(D), .ROW_OFFSETS_AUTO(1'b1)) u4 (
      .clk(clk), .rst(rst), .flush(flush), .in_bus(i4), .out_bus(o4), .occupancy(occ4));
   aes_shift_rows_pipe #(.NB(8), .PIPE_DEPTH(D), .ROW_OFFSETS_AUTO(1'b1)) u8 (
      .clk(clk), .rst(rst), .flush(flush), .in_bus(i8), .out_bus(o8), .occupancy(occ8));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pops4 = 0;
   int pops8 = 0;
   bit lat_on = 1'b1;
   bit acc4, acc8;
   bit hold4 = 1'b0;
   logic [127:0] hdata4;
   logic hinv4;
   logic [255:0] pend4, pend8, last8;
   item_t exp4[$];
   item_t exp8[$];

   // Rijndael ShiftRows on a state of nb columns, word right-aligned in 256 bits.
   function automatic logic [255:0] ref_sr(input int nb, input logic [255:0] x, input logic inv);
      logic [7:0] b [32];
      logic [7:0] o [32];
      int off [4];
      logic [255:0] y;
      off = '{0, 1, (nb == 8) ? 3 : 2, (nb == 8) ? 4 : 3};
      for (int k = 0; k < 4*nb; k++) b[k] = x[(4*nb-1-k)*8 +: 8];
      for (int c = 0; c < nb; c++)
         for (int r = 0; r < 4; r++)
            o[4*c+r] = b[4*(inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb) + r];
      y = '0;
      for (int k = 0; k < 4*nb; k++) y[(4*nb-1-k)*8 +: 8] = o[k];
      return y;
   endfunction

   function automatic logic [127:0] rnd128();
      logic [127:0] v;
      for (int i = 0; i < 4; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Evaluate the handshakes of the coming edge, then advance one cycle.
   task automatic tick();
      item_t e;
      #2;
      chk("u4_occupancy", 256'(occ4), 256'(exp4.size()));
      chk("u8_occupancy", 256'(occ8), 256'(exp8.size()));
      chk("u4_in_ready", 256'(i4.ready), 256'(!flush && !rst && (exp4.size() < D || o4.ready)));
      if (hold4 && o4.valid) begin
         chk("u4_hold_data", 256'(o4.data), 256'(hdata4));
         chk("u4_hold_inv", 256'(o4.inverse), 256'(hinv4));
      end
      hold4  = o4.valid && !o4.ready;
      hdata4 = o4.data;
      hinv4  = o4.inverse;
      if (o4.valid && o4.ready) begin
         pops4++;
         if (exp4.size() == 0) chk("u4_spurious_output", 256'(1), 256'(0));
         else begin
            e = exp4.pop_front();
            chk("u4_data", 256'(o4.data), e.d);
            chk("u4_inverse", 256'(o4.inverse), 256'(e.inv));
            if (lat_on) chk("u4_latency", 256'(cyc - e.cyc), 256'(D));
         end
      end
      if (o8.valid && o8.ready) begin
         pops8++;
         last8 = o8.data;
         if (exp8.size() == 0) chk("u8_spurious_output", 256'(1), 256'(0));
         else begin
            e = exp8.pop_front();
            chk("u8_data", o8.data, e.d);
            chk("u8_inverse", 256'(o8.inverse), 256'(e.inv));
            if (lat_on) chk("u8_latency", 256'(cyc - e.cyc), 256'(D));
         end
      end
      if (i4.valid && i4.ready) begin
         exp4.push_back('{d: pend4, inv: i4.inverse, cyc: cyc});
         acc4 = 1'b1;
      end
      if (i8.valid && i8.ready) begin
         exp8.push_back('{d: pend8, inv: i8.inverse, cyc: cyc});
         acc8 = 1'b1;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drive4(input logic [127:0] d, input logic inv, input logic [255:0] e);
      i4.valid = 1'b1; i4.data = d; i4.inverse = inv; pend4 = e;
   endtask

   task automatic send4(input logic [127:0] d, input logic inv, input logic [255:0] e);
      drive4(d, inv, e);
      acc4 = 1'b0;
      for (int n = 0; n < 10 && !acc4; n++) tick();
      i4.valid = 1'b0;
      if (!acc4) chk("u4_accept_timeout", 256'(0), 256'(1));
   endtask

   task automatic send8(input logic [255:0] d, input logic inv, input logic [255:0] e);
      i8.valid = 1'b1; i8.data = d; i8.inverse = inv; pend8 = e;
      acc8 = 1'b0;
      for (int n = 0; n < 10 && !acc8; n++) tick();
      i8.valid = 1'b0;
      if (!acc8) chk("u8_accept_timeout", 256'(0), 256'(1));
   endtask

   task automatic drain();
      i4.valid = 1'b0; i8.valid = 1'b0; o4.ready = 1'b1; o8.ready = 1'b1;
      for (int n = 0; n < 20 && (exp4.size() != 0 || exp8.size() != 0); n++) tick();
      chk("drain_empty", 256'(exp4.size() + exp8.size()), 256'(0));
   endtask

   initial begin
      logic [127:0] w [6];
      logic [127:0] d;
      logic [255:0] seq8;
      logic [255:0] t8;
      logic         iv;
      int idx, p0;

      i4.valid = 1'b0; i4.data = '0; i4.inverse = 1'b0; o4.ready = 1'b1;
      i8.valid = 1'b0; i8.data = '0; i8.inverse = 1'b0; o8.ready = 1'b1;

      // Reset state
      #3;
      chk("rst_out_valid", 256'(o4.valid), 256'(0));
      chk("rst_out_data", 256'(o4.data), 256'(0));
      chk("rst_out_inverse", 256'(o4.inverse), 256'(0));
      chk("rst_occupancy", 256'(occ4), 256'(0));
      chk("rst_in_ready", 256'(i4.ready), 256'(0));
      chk("rst_in_ready8", 256'(i8.ready), 256'(0));
      @(posedge clk); @(posedge clk); #2 rst = 1'b0;
      @(posedge clk); #1;

      // Known NB=4 vectors
      send4(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 256'(128'hd4bf5d30e0b452aeb84111f11e2798e5));
      send4(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 256'(128'hd42711aee0bf98f1b8b45de51e415230));
      send4(128'h000102030405060708090a0b0c0d0e0f, 1'b1, 256'(128'h000d0a0704010e0b0805020f0c090603));
      drain();

      // NB=8 forward and round trip
      for (int k = 0; k < 32; k++) seq8[(31-k)*8 +: 8] = 8'(k);
      send8(seq8, 1'b0, ref_sr(8, seq8, 1'b0));
      drain();
      t8 = last8;
      chk("nb8_first_columns", 256'(t8[255:192]), 256'(64'h00050e1304091217));
      send8(t8, 1'b1, seq8);
      drain();

      // Back-pressure with alternating direction
      lat_on = 1'b0;
      for (int i = 0; i < 6; i++) w[i] = rnd128();
      o4.ready = 1'b0;
      idx = 0;
      p0 = pops4;
      for (int t = 0; t < 5; t++) begin
         drive4(w[idx], idx[0], ref_sr(4, 256'(w[idx]), idx[0]));
         acc4 = 1'b0;
         tick();
         if (acc4) idx++;
      end
      chk("bp_occupancy_full", 256'(occ4), 256'(2));
      chk("bp_in_ready_low", 256'(i4.ready), 256'(0));
      o4.ready = 1'b1;
      for (int n = 0; n < 30 && idx < 6; n++) begin
         drive4(w[idx], idx[0], ref_sr(4, 256'(w[idx]), idx[0]));
         acc4 = 1'b0;
         tick();
         if (acc4) idx++;
      end
      drain();
      chk("bp_all_accepted", 256'(idx), 256'(6));
      chk("bp_output_count", 256'(pops4 - p0), 256'(6));

      // Continuous streaming
      lat_on = 1'b1;
      for (int i = 0; i < 16; i++) begin
         d = rnd128();
         iv = 1'($urandom_range(0, 1));
         drive4(d, iv, ref_sr(4, 256'(d), iv));
         acc4 = 1'b0;
         tick();
         chk("stream_accept", 256'(acc4), 256'(1));
         if (i >= 1) begin
            chk("stream_occupancy", 256'(occ4), 256'(D));
            chk("stream_out_valid", 256'(o4.valid), 256'(1));
         end
      end
      drain();

      // Flush with a full pipeline
      o4.ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         d = rnd128();
         drive4(d, i[0], ref_sr(4, 256'(d), i[0]));
         tick();
      end
      flush = 1'b1;
      d = rnd128();
      drive4(d, 1'b0, ref_sr(4, 256'(d), 1'b0));
      acc4 = 1'b0;
      tick();
      chk("flush_input_dropped", 256'(acc4), 256'(0));
      flush = 1'b0;
      i4.valid = 1'b0;
      exp4.delete(); exp8.delete(); hold4 = 1'b0;
      chk("flush_occupancy", 256'(occ4), 256'(0));
      chk("flush_out_valid", 256'(o4.valid), 256'(0));

      // Asynchronous reset with a full pipeline
      for (int i = 0; i < 2; i++) begin
         d = rnd128();
         drive4(d, i[0], ref_sr(4, 256'(d), i[0]));
         tick();
      end
      i4.valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk("arst_out_valid", 256'(o4.valid), 256'(0));
      chk("arst_out_data", 256'(o4.data), 256'(0));
      chk("arst_out_inverse", 256'(o4.inverse), 256'(0));
      chk("arst_occupancy", 256'(occ4), 256'(0));
      chk("arst_in_ready", 256'(i4.ready), 256'(0));
      exp4.delete(); exp8.delete(); hold4 = 1'b0;
      @(posedge clk); #2 rst = 1'b0;
      @(posedge clk); #1;
      o4.ready = 1'b1;
      d = rnd128();
      send4(d, 1'b1, ref_sr(4, 256'(d), 1'b1));
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/aes_shift_rows_pipe.md
Name: aes_shift_rows_pipe

Overview:
Parametrised, pipelined ShiftRows / InvShiftRows unit for the AES/Rijndael datapath in the SD-card encrypt/decrypt core. It supports Rijndael block widths of Nb = 4, 6 or 8 columns and a per-transaction direction bit (forward for encrypt, inverse for decrypt). It sits between SubBytes and MixColumns in the round pipeline and carries data through an elastic valid/ready register pipeline, so that downstream stalls are absorbed without data loss.

Parameters:
NB, 4, state columns (legal: 4, 6, 8); data width W = 32*NB
PIPE_DEPTH, 2, number of register stages (legal 1..4); minimum latency in cycles
ROW_OFFSETS_AUTO, 1, 1 = Rijndael offsets derived from NB; 0 = fixed offsets 0,1,2,3

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous clear of all pipeline contents
in_valid  in  1  input word valid
in_ready  out  1  unit can accept the input word this cycle
in_data  in  W  input state, byte k = in_data[(W/8-1-k)*8 +: 8]
in_inverse  in  1  0 = ShiftRows, 1 = InvShiftRows for this word
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts the output word
out_data  out  W  transformed state, same byte ordering as in_data
out_inverse  out  1  in_inverse carried alongside the word
occupancy  out  3  number of valid stages (0..PIPE_DEPTH)

Behaviour:
- State mapping: byte k is at row r = k mod 4, column c = k div 4 (column-major).
- Row offsets C_r: C0=0 and C1=1. C2 is 3 when NB=8, otherwise 2. C3 is 4 when NB=8, otherwise 3. With ROW_OFFSETS_AUTO=0, the offsets are 0,1,2,3 for every NB.
- Forward transform: out(r,c) = in(r, (c+C_r) mod NB).
- Inverse transform: out(r,c) = in(r, (c-C_r+NB) mod NB).
- Pure byte permutation; no arithmetic on byte values.
- The permutation is applied combinationally to in_data, selected by in_inverse. The result and in_inverse are captured into stage 0. Later stages only copy.
- Stage i holds valid_i, data_i and inv_i.
  - ready_i = ~valid_i | ready_{i+1}, with ready_{PIPE_DEPTH} = out_ready.
  - in_ready = ready_0. This is a combinational path from out_ready.
  - Stage i loads from stage i-1 (or from the input for stage 0) when ready_i = 1.
  - valid_i takes the upstream valid, qualified by the upstream handshake.
- Handshake: a transfer occurs when valid & ready are both high on the same edge.
  - in_data and in_inverse are sampled only on an accepted cycle.
  - out_data, out_inverse and out_valid hold stable while out_valid=1 and out_ready=0.
- Latency: exactly PIPE_DEPTH cycles from input acceptance to out_valid with no stalls. Throughput is one word per cycle.
- Full pipeline with out_ready=0: in_ready=0 and no word is lost or overwritten.
- Full pipeline with out_ready=1 and in_valid=1: simultaneous output and input transfer in the same cycle; occupancy is unchanged.
- Empty pipeline: out_valid=0 and occupancy=0. out_data retains its last value and is don't-care to consumers.
- occupancy is the popcount of valid_i, updated on the same edge as the valids.
- Words are delivered in order. Mixed forward and inverse words interleave freely with no bubbles.
- flush=1: all valid_i cleared on the next edge and occupancy becomes 0. Any input presented in the same cycle is dropped, and in_ready is forced to 0 during flush.
- Reset: asynchronous, effective immediately on rst high.
  - All valid_i=0, data_i=0, inv_i=0.
  - Outputs during reset: out_valid=0, out_data=0, out_inverse=0, occupancy=0, in_ready=0.
  - in_ready may assert from the first edge after rst deasserts.
  - Reset mid-transaction discards in-flight words with no partial output.
- Illegal NB or PIPE_DEPTH values are a compile-time error (elaboration assertion).

Test Plan:
- NB=4, forward, in_data=d42711aee0bf98f1b8b45de51e415230 -> out_data=d4bf5d30e0b452aeb84111f11e2798e5 after exactly PIPE_DEPTH cycles, out_inverse=0.
- NB=4, inverse, input d4bf5d30e0b452aeb84111f11e2798e5 -> d42711aee0bf98f1b8b45de51e415230. Also input 000102…0f -> 000d0a07 04010e0b 0805020f 0c090603.
- NB=8, forward, input bytes 00..1f -> first column 00 05 0e 13, second column 04 09 12 17. The inverse of that output must return 00..1f.
- Back-pressure, PIPE_DEPTH=2: stream 6 words alternating forward/inverse with out_ready held low for 5 cycles.
  - in_ready=0 once occupancy=2.
  - After release, all 6 words emerge in order, correctly transformed and flagged, with no duplicates.
- Continuous in_valid=1 and out_ready=1 for 16 words -> one output per cycle and occupancy constant at PIPE_DEPTH.
- Mid-stream disturbances with occupancy=2:
  - flush -> occupancy=0 and out_valid=0 next cycle.
  - rst asserted asynchronously between edges -> outputs zero immediately, and the first word after rst deasserts is delivered correctly.
